// File: rtl/instr_queue.sv
// IF->ID instruction FIFO: a pushed word is visible one cycle after its push edge, and a taken branch flushes the whole queue.
// InReady is computed from registered count only, so there is no push when full. When the queue is empty, ID sees a NOP bubble.
module instr_queue #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic [31:0]   InstrIn,
  input  logic [31:0]   PCIncIn,
  input  logic          InValid,
  output logic          InReady,
  input  logic          Flush,
  input  logic          Stall,
  output logic [31:0]   InstrOut,
  output logic [31:0]   PCIncOut,
  output logic          OutValid,
  output logic [CW-1:0] Count
);

  logic [63:0]   mem [DEPTH];
  logic [CW-2:0] wp;
  logic [CW-2:0] rp;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic [63:0]   head;

  assign InReady  = (count != CW'(DEPTH));
  assign OutValid = (count != '0);
  assign Count    = count;

  assign push = InValid & InReady & ~Flush;
  assign pop  = OutValid & ~Stall & ~Flush;

  assign head     = mem[rp];
  assign InstrOut = OutValid ? head[63:32] : 32'h0000_0000;
  assign PCIncOut = OutValid ? head[31:0]  : 32'h0000_0000;

  // Pointers wrap naturally at DEPTH (a power of two); full vs empty comes from count alone.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (Flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is deliberately left unreset; only pointers and count define what is valid.
  always_ff @(posedge Clock) begin
    if (push) mem[wp] <= {InstrIn, PCIncIn};
  end

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: the driver queues expected words on acceptance, and a negedge monitor checks every pop.
module tb_instr_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          Clock = 1'b0;
  logic          nReset;
  logic [31:0]   InstrIn;
  logic [31:0]   PCIncIn;
  logic          InValid;
  logic          InReady;
  logic          Flush;
  logic          Stall;
  logic [31:0]   InstrOut;
  logic [31:0]   PCIncOut;
  logic          OutValid;
  logic [CW-1:0] Count;

  logic [63:0] expq [$];
  int n_cmp = 0;
  int n_err = 0;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .Clock    (Clock),
    .nReset   (nReset),
    .InstrIn  (InstrIn),
    .PCIncIn  (PCIncIn),
    .InValid  (InValid),
    .InReady  (InReady),
    .Flush    (Flush),
    .Stall    (Stall),
    .InstrOut (InstrOut),
    .PCIncOut (PCIncOut),
    .OutValid (OutValid),
    .Count    (Count)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops happen on the coming edge when OutValid & !Stall & !Flush.
  always @(negedge Clock) begin
    if (nReset === 1'b1) begin
      if (OutValid && !Stall && !Flush) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL pop_underflow: got %h with no word expected", InstrOut);
        end else begin
          logic [63:0] e;
          e = expq.pop_front();
          chk("pop_instr", InstrOut, e[63:32]);
          chk("pop_pcinc", PCIncOut, e[31:0]);
        end
      end else if (!OutValid) begin
        chk("empty_nop", InstrOut | PCIncOut, 32'h0);
      end
    end
  end

  // Called just after a posedge. It drives one cycle and returns just after the next posedge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic st, input logic fl);
    InValid = v;
    InstrIn = ins;
    PCIncIn = pc;
    Stall   = st;
    Flush   = fl;
    @(negedge Clock);
    if (fl) expq.delete();
    else if (v && InReady) expq.push_back({ins, pc});
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    nReset  = 1'b0;
    InValid = 1'b0;
    InstrIn = '0;
    PCIncIn = '0;
    Stall   = 1'b0;
    Flush   = 1'b0;
    #12;
    chk("rst_count",   32'(Count),    32'd0);
    chk("rst_outvld",  32'(OutValid), 32'd0);
    chk("rst_inready", 32'(InReady),  32'd1);
    chk("rst_instr",   InstrOut,      32'h0);
    #2 nReset = 1'b1;
    @(posedge Clock);
    #1;

    // Streaming: each word appears one cycle after its push, and occupancy stays at 1.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 32'h1000_0000 + 32'(i), 32'(4 * i), 1'b0, 1'b0);
      chk("stream_count", 32'(Count), 32'd1);
      chk("stream_head",  InstrOut,   32'h1000_0000 + 32'(i));
    end
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("stream_drained", 32'(Count), 32'd0);

    // Fill under stall: after 4 pushes the queue is full, and the 5th offer is refused.
    for (int i = 1; i <= 4; i++) step(1'b1, 32'h2000_0000 + 32'(i), 32'h100 + 32'(4 * i), 1'b1, 1'b0);
    chk("fill_count",   32'(Count),   32'd4);
    chk("fill_inready", 32'(InReady), 32'd0);
    step(1'b1, 32'h2000_0005, 32'h114, 1'b1, 1'b0);
    chk("fill_5th_refused", 32'(Count), 32'd4);
    chk("fill_head",        InstrOut,   32'h2000_0001);
    // Full with a pop: the pop occurs, but no push is taken because InReady was low.
    step(1'b1, 32'h2000_0005, 32'h114, 1'b0, 1'b0);
    chk("full_pop_count",   32'(Count),   32'd3);
    chk("full_pop_inready", 32'(InReady), 32'd1);
    // Push and pop together leave occupancy at 3.
    step(1'b1, 32'h2000_0005, 32'h114, 1'b0, 1'b0);
    chk("pushpop_count", 32'(Count), 32'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("fill_drained", 32'(Count), 32'd0);

    // Flush with three queued words and one push pending.
    for (int i = 1; i <= 3; i++) step(1'b1, 32'h3000_0000 + 32'(i), 32'h200 + 32'(4 * i), 1'b1, 1'b0);
    chk("preflush_count", 32'(Count), 32'd3);
    step(1'b1, 32'h3000_0004, 32'h210, 1'b0, 1'b1);
    chk("flush_count",   32'(Count),    32'd0);
    chk("flush_outvld",  32'(OutValid), 32'd0);
    chk("flush_inready", 32'(InReady),  32'd1);
    step(1'b1, 32'hDEAD_BEEF, 32'h300, 1'b1, 1'b0);
    chk("postflush_count", 32'(Count),    32'd1);
    chk("postflush_head",  InstrOut,      32'hDEAD_BEEF);
    chk("postflush_pc",    PCIncOut,      32'h300);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset mid-operation with count=3 takes effect immediately.
    for (int i = 1; i <= 3; i++) step(1'b1, 32'h4000_0000 + 32'(i), 32'h400 + 32'(4 * i), 1'b1, 1'b0);
    nReset = 1'b0;
    #1;
    chk("midrst_count",   32'(Count),    32'd0);
    chk("midrst_outvld",  32'(OutValid), 32'd0);
    chk("midrst_instr",   InstrOut,      32'h0);
    chk("midrst_inready", 32'(InReady),  32'd1);
    expq.delete();
    Stall = 1'b0;
    InValid = 1'b0;
    #1 nReset = 1'b1;
    @(posedge Clock);
    #1;

    // Wrap-around with random stall: the scoreboard checks ordering and occupancy is bounded.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h5000_0000 + 32'(i), 32'h500 + 32'(4 * i), 1'($urandom_range(0, 1)), 1'b0);
      n_cmp++;
      if (Count > CW'(DEPTH)) begin
        n_err++;
        $display("FAIL wrap_bound: got count %0d expected at most %0d", Count, DEPTH);
      end
    end
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("wrap_drained",  32'(Count),       32'd0);
    chk("wrap_sb_empty", 32'(expq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
